// File: rtl/dds_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dds_pkg
// Description : Shared types and default constants for the DDS sample
//               sequencer (FSM state encoding, default parameter values).
// Revision    : 1.0 - initial release
// ============================================================================
package dds_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    ISSUE     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  localparam int PHASE_W_DEF  = 32;
  localparam int ADDR_W_DEF   = 12;
  localparam int DATA_W_DEF   = 12;
  localparam int TICK_DIV_DEF = 100;
  localparam int ROM_LAT_DEF  = 1;

  // Offset-binary zero level of a DATA_W_DEF-bit sample
  localparam int MIDSCALE = 2 ** (DATA_W_DEF - 1);

endpackage
`default_nettype wire

// File: rtl/sample_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : sample_tick_gen
// Description : Sample pacing counter. Counts 0..TICK_DIV-1 while en is high
//               and asserts tick on the wrap; held at 0 while en is low.
//               TICK_DIV must be at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_tick_gen #(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: wrap on the last count, park at zero when disabled
  always_comb begin
    tick  = en && (cnt_q == CNT_LAST);
    cnt_d = cnt_q;
    if (!en || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dds_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dds_sample_sequencer
// Description : Paced DDS phase accumulator feeding a waveform ROM; captures
//               each sample and hands it to the SPI DAC driver with a go/ready
//               handshake. Sticky underrun flag for ticks that arrive while a
//               transfer is still in flight (that tick's transfer is dropped).
//               Optional macro DDS_QUARTER_WAVE_EN: quarter-sine ROM with
//               quadrant mirroring of address and sample.
// Revision    : 1.0 - initial release
// ============================================================================
module dds_sample_sequencer
  import dds_pkg::*;
#(
  parameter int PHASE_W  = PHASE_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int ROM_LAT  = ROM_LAT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PHASE_W-1:0] tune_word,
  input  logic               tune_load,
  input  logic               clr_underrun,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_data,
  output logic [DATA_W-1:0]  sample,
  output logic               go,
  input  logic               ready,
  output logic               busy,
  output logic               underrun
);

  // FETCH spans the address register cycle plus the ROM latency
  localparam int FCNT_W = $clog2(ROM_LAT + 2);
  localparam logic [FCNT_W-1:0] FETCH_LAST = FCNT_W'(ROM_LAT);

  logic               tick;
  logic [PHASE_W-1:0] phase_q, phase_d, phase_next;
  logic [PHASE_W-1:0] tune_q, tune_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d, addr_next;
  logic [DATA_W-1:0]  sample_q, sample_d, sample_cap;
  logic [FCNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;
  logic               go_q, go_d;
  logic               busy_q, busy_d;
  logic               underrun_q, underrun_d;
  state_t             state_q, state_d;

  sample_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

`ifdef DDS_QUARTER_WAVE_EN
  localparam int IDX_W = ADDR_W - 2;

  logic [1:0]         quad;
  logic [IDX_W-1:0]   idx;
  logic               mirror_q, mirror_d;
  logic [ROM_LAT-1:0] mirror_pipe_q, mirror_pipe_d;

  // Quadrant folding: odd quadrants read the table backwards
  always_comb begin
    phase_next = phase_q + tune_q;
    quad       = phase_next[PHASE_W-1 -: 2];
    idx        = phase_next[PHASE_W-3 -: IDX_W];
    if (quad[0]) begin
      idx = ~idx;
    end
    addr_next  = {2'b00, idx};
    mirror_d   = tick ? quad[1] : mirror_q;
    sample_cap = mirror_pipe_q[ROM_LAT-1] ? ~rom_data : rom_data;
  end

  // The sign bit travels with the ROM read so it lines up with rom_data
  if (ROM_LAT == 1) begin : g_mirror_lat1
    assign mirror_pipe_d = mirror_q;
  end else begin : g_mirror_shift
    assign mirror_pipe_d = {mirror_pipe_q[ROM_LAT-2:0], mirror_q};
  end

  // Sign-bit pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mirror_q      <= 1'b0;
      mirror_pipe_q <= '0;
    end else begin
      mirror_q      <= mirror_d;
      mirror_pipe_q <= mirror_pipe_d;
    end
  end
`else
  // Full-table addressing from the top phase bits
  always_comb begin
    phase_next = phase_q + tune_q;
    addr_next  = phase_next[PHASE_W-1 -: ADDR_W];
    sample_cap = rom_data;
  end
`endif

  // Phase accumulator and ROM address advance once per tick, in any state
  always_comb begin
    tune_d     = tune_load ? tune_word : tune_q;
    phase_d    = phase_q;
    rom_addr_d = rom_addr_q;
    if (tick) begin
      phase_d    = phase_next;
      rom_addr_d = addr_next;
    end
  end

  // Transfer sequencing, underrun tracking and registered handshake outputs
  always_comb begin
    state_d     = state_q;
    fetch_cnt_d = fetch_cnt_q;
    sample_d    = sample_q;
    go_d        = 1'b0;
    underrun_d  = underrun_q;

    if (tick && (state_q != IDLE)) begin
      underrun_d = 1'b1;
    end else if (clr_underrun) begin
      underrun_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d     = FETCH;
          fetch_cnt_d = '0;
        end
      end
      FETCH: begin
        if (fetch_cnt_q == FETCH_LAST) begin
          sample_d = sample_cap;
          state_d  = ISSUE;
        end else begin
          fetch_cnt_d = fetch_cnt_q + 1'b1;
        end
      end
      ISSUE: begin
        if (ready) begin
          go_d    = 1'b1;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!ready) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fetch_cnt_q <= '0;
      phase_q     <= '0;
      tune_q      <= '0;
      rom_addr_q  <= '0;
      sample_q    <= '0;
      go_q        <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_cnt_q <= fetch_cnt_d;
      phase_q     <= phase_d;
      tune_q      <= tune_d;
      rom_addr_q  <= rom_addr_d;
      sample_q    <= sample_d;
      go_q        <= go_d;
      busy_q      <= busy_d;
      underrun_q  <= underrun_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign sample   = sample_q;
  assign go       = go_q;
  assign busy     = busy_q;
  assign underrun = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_dds_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dds_sample_sequencer
// Description : Scoreboard bench for dds_sample_sequencer with a behavioural
//               DDS model, synchronous ROM model and SPI driver model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dds_sample_sequencer;

  localparam int PW    = 32;
  localparam int AW    = 12;
  localparam int DW    = 12;
  localparam int TD    = 100;
  localparam int SHIFT = PW - AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [PW-1:0] tune_word = '0;
  logic          tune_load = 1'b0;
  logic          clr_underrun = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data = '0;
  logic [DW-1:0] sample;
  logic          go;
  logic          ready = 1'b1;
  logic          busy;
  logic          underrun;

  dds_sample_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .tune_word    (tune_word),
    .tune_load    (tune_load),
    .clr_underrun (clr_underrun),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .sample       (sample),
    .go           (go),
    .ready        (ready),
    .busy         (busy),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint addr;
    longint smp;
    longint cyc;
  } exp_t;

  exp_t   sb[$];
  int     n_chk  = 0;
  int     n_pass = 0;
  int     hold   = 30;
  longint cyc    = 0;
  logic   m_ur   = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // ROM contents: arbitrary scramble for full table, identity for quarter table
  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
`ifdef DDS_QUARTER_WAVE_EN
    return a;
`else
    return {a[3:0], a[11:4]} ^ 12'h5A3;
`endif
  endfunction

  // Expected ROM address and sample for a given phase
  task automatic expect_of(input longint unsigned ph, output longint addr, output longint smp);
`ifdef DDS_QUARTER_WAVE_EN
    longint unsigned q, i;
    q = ph >> (PW - 2);
    i = (ph >> SHIFT) % 1024;
    if (q % 2 == 1) i = 1023 - i;
    addr = i;
    smp  = (q >= 2) ? 4095 - i : i;
`else
    addr = ph >> SHIFT;
    smp  = rom_f(AW'(addr));
`endif
  endtask

  // Synchronous ROM, one cycle latency
  initial forever begin
    @(posedge clk);
    rom_data <= rom_f(rom_addr);
  end

  // SPI driver: drops ready 2 cycles after go, returns hold cycles later
  initial begin
    int dc;
    dc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ready = 1'b1;
        dc    = 0;
      end else if (go) begin
        dc = 1;
      end else if (dc != 0) begin
        dc++;
        if (dc == 3) ready = 1'b0;
        if (dc == 3 + hold) begin
          ready = 1'b1;
          dc    = 0;
        end
      end
    end
  end

  // Reference model: ticks every TD enabled cycles; one transfer in flight at a time
  initial begin
    longint unsigned mphase, mtune;
    int   mcnt;
    bit   mbusy, mseen, tk, acc;
    exp_t e;
    mphase = 0; mtune = 0; mcnt = 0; mbusy = 0; mseen = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        mphase = 0; mtune = 0; mcnt = 0; mbusy = 0; mseen = 0;
        m_ur = 1'b0;
        sb.delete();
      end else begin
        tk  = 0;
        acc = 0;
        if (en) begin
          mcnt++;
          if (mcnt == TD) begin
            tk   = 1;
            mcnt = 0;
          end
        end else begin
          mcnt = 0;
        end
        if (tk && mbusy) m_ur = 1'b1;
        else if (clr_underrun) m_ur = 1'b0;
        if (tk) begin
          mphase = (mphase + mtune) % (64'd1 << PW);
          if (!mbusy) begin
            expect_of(mphase, e.addr, e.smp);
            e.cyc = cyc;
            sb.push_back(e);
            acc = 1;
          end
        end
        if (mbusy) begin
          if (mseen && ready) mbusy = 0;
          else if (!ready) mseen = 1;
        end
        if (acc) begin
          mbusy = 1;
          mseen = 0;
        end
        if (tune_load) mtune = tune_word;
      end
    end
  end

  // Monitor: compare each go against the scoreboard, underrun every cycle
  initial forever begin
    exp_t e;
    @(negedge clk);
    chk("underrun", underrun, m_ur);
    if (go) begin
      if (sb.size() == 0) begin
        chk("unexpected_go", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("rom_addr", rom_addr, e.addr);
        chk("sample", sample, e.smp);
        chk("go_latency", cyc - e.cyc, 3);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [PW-1:0] w);
    tune_word = w;
    tune_load = 1'b1;
    cycles(1);
    tune_load = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_underrun = 1'b1;
    cycles(1);
    clr_underrun = 1'b0;
  endtask

  task automatic wait_go();
    bit seen;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (go) seen = 1;
    end
    if (!seen) chk("go_timeout", 0, 1);
    cycles(1);
  endtask

  task automatic wait_busy();
    bit seen;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    if (!seen) chk("busy_timeout", 0, 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_go"}, go, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sample"}, sample, 0);
    chk({tag, "_underrun"}, underrun, 0);
    chk({tag, "_rom_addr"}, rom_addr, 0);
  endtask

  initial begin
    rst = 1'b1;
    cycles(3);
    check_zero("reset");
    rst = 1'b0;

    // Basic stepping, then phase wrap with a half-cycle step
    load(32'h0010_0000);
    en = 1'b1;
    cycles(TD * 5 + 10);
    load(32'h8010_0000);
    cycles(TD * 5);

    // Random tuning words loaded at random points
    repeat (6) begin
      load($urandom);
      cycles($urandom_range(50, 250));
    end

    // Slow driver: every other tick missed, clear while misses continue
    hold = 150;
    load(32'h0010_0000);
    cycles(TD * 6);
    pulse_clr();
    cycles(TD * 4);
    hold = 30;
    cycles(TD * 2);
    pulse_clr();
    cycles(TD);

    // Tuning change while a transfer is in flight
    wait_go();
    cycles(5);
    load(32'h0020_0000);
    cycles(TD * 3);

    // Reset during WAIT_DONE, then tune=0 repeats address 0
    wait_go();
    cycles(10);
    rst = 1'b1;
    cycles(1);
    check_zero("rst_mid");
    rst = 1'b0;
    cycles(TD * 3 + 10);
    load(32'h0010_0000);
    cycles(TD * 2);

    // Disable mid-transfer: current transfer finishes, nothing further
    wait_busy();
    cycles(1);
    en = 1'b0;
    cycles(TD * 3);
    chk("busy_after_disable", busy, 0);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
